// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for EX: one op in flight, stalls the pipeline
// while busy, returns a registered result with a one-cycle done pulse.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      mode_q, mode_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;     // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;   // product or quotient must be negated
  logic            rneg_q, rneg_d; // remainder takes the dividend sign
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_div;
  logic            sgn1, sgn2;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN:0]   add_w;
  logic [XLEN:0]   shl_w;
  logic            q_bit;
  logic [XLEN-1:0] diff_w;
  logic [2*XLEN-1:0] prod_w, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign is_div = mode_q[2];
  assign sgn1   = (mode_q == M_MULH) || (mode_q == M_MULHSU) ||
                  (mode_q == M_DIV)  || (mode_q == M_REM);
  assign sgn2   = (mode_q == M_MULH) || (mode_q == M_DIV) || (mode_q == M_REM);
  assign a_neg  = sgn1 & src1_q[XLEN-1];
  assign b_neg  = sgn2 & src2_q[XLEN-1];

  // An XLEN-bit unsigned magnitude already holds 2^(XLEN-1) for the most negative input.
  assign a_mag  = a_neg ? (~src1_q + XLEN'(1)) : src1_q;
  assign b_mag  = b_neg ? (~src2_q + XLEN'(1)) : src2_q;

  assign div_zero = (src2_q == '0);
  assign div_ovf  = ((mode_q == M_DIV) || (mode_q == M_REM)) &&
                    (src1_q == {1'b1, {(XLEN-1){1'b0}}}) && (src2_q == '1);

  assign add_w  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign shl_w  = {hi_q, lo_q[XLEN-1]};
  assign q_bit  = (shl_w >= {1'b0, opb_q});
  assign diff_w = shl_w[XLEN-1:0] - opb_q;

  assign prod_w   = {hi_q, lo_q};
  assign prod_fix = neg_q  ? (~prod_w + (2*XLEN)'(1)) : prod_w;
  assign quo_fix  = neg_q  ? (~lo_q + XLEN'(1)) : lo_q;
  assign rem_fix  = rneg_q ? (~hi_q + XLEN'(1)) : hi_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          mode_d  = mode;
          src1_d  = src1;
          src2_d  = src2;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d  = CW'(XLEN);
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          hi_d   = '0;
          if (is_div) begin
            lo_d    = a_mag;
            opb_d   = b_mag;
            state_d = S_CALC;
            // Architected divide corner cases skip iteration; FIX then passes them unchanged.
            if (div_zero) begin
              hi_d    = src1_q;
              lo_d    = '1;
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_FIX;
            end else if (div_ovf) begin
              lo_d    = src1_q;
              neg_d   = 1'b0;
              rneg_d  = 1'b0;
              state_d = S_FIX;
            end
          end else begin
            lo_d    = b_mag;
            opb_d   = a_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div) begin
            hi_d = q_bit ? diff_w : shl_w[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], q_bit};
          end else begin
            {hi_d, lo_d} = {add_w, lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          unique case (mode_q)
            M_MUL:                    result_d = prod_fix[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:            result_d = quo_fix;
            M_REM, M_REMU:            result_d = rem_fix;
            default:                  result_d = result_q;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Handshake: start is honoured only in IDLE and only without flush; stall covers that
  // acceptance cycle plus every busy cycle; done pulses for one cycle with result valid.
  assign busy   = (state_q != S_IDLE);
  assign stall  = (start & ~flush) | busy;
  assign done   = done_q;
  assign result = result_q;

endmodule
